// File: rtl/dpa_time_render.sv
// dpa_time_render: real-time clock plus "HH:MM:SS" overlay renderer on the image-memory write port.
// Define TIME_RENDER_TRANSPARENT_EN to skip background pixels so the frame buffer shows through.
module dpa_time_render #(
    parameter int          CLK_PER_SEC = 1000000,
    parameter int          X0          = 8,
    parameter int          Y0          = 8,
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_time_en,
    input  logic [23:0] init_time,
    output logic [23:0] curr_time,
    output logic        sec_tick,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [19:0] fb_addr,
    output logic        im_req,
    input  logic        im_gnt,
    output logic [19:0] im_a,
    output logic [23:0] im_d,
    output logic        im_wen_n,
    output logic [3:0]  font_code,
    output logic [2:0]  font_row,
    input  logic [7:0]  font_bits
);

    localparam int              CW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_PER_SEC - 1);
    localparam logic [19:0]     ORIGIN  = 20'(Y0 * 256 + X0);

    typedef enum logic [1:0] {IDLE, SNAP, DRAW, FIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    hh, mm, ss;
    logic          ss_wrap, mm_wrap, hh_wrap;
    logic [23:0]   next_time;
    logic [23:0]   snap;
    logic [8:0]    cur;
    logic [2:0]    chr, row, col;
    logic [3:0]    glyph [8];
    logic          drawing, pixel_fg, advance;

    function automatic logic [3:0] tens(input logic [7:0] v);
        tens = 4'(v / 8'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [7:0] v);
        ones = 4'(v % 8'd10);
    endfunction

    // >= rather than == so out-of-range loaded values roll back into range
    assign {hh, mm, ss} = curr_time;
    assign ss_wrap      = ss >= 8'd59;
    assign mm_wrap      = mm >= 8'd59;
    assign hh_wrap      = hh >= 8'd23;
    assign next_time    = {!(ss_wrap && mm_wrap) ? hh : hh_wrap ? 8'd0 : hh + 8'd1,
                           !ss_wrap ? mm : mm_wrap ? 8'd0 : mm + 8'd1,
                           ss_wrap ? 8'd0 : ss + 8'd1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            curr_time <= '0;
            sec_tick  <= 1'b0;
        end else if (init_time_en) begin
            cnt       <= '0;
            curr_time <= init_time;
            sec_tick  <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt       <= '0;
            curr_time <= next_time;
            sec_tick  <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            sec_tick  <= 1'b0;
        end
    end

    assign {chr, row, col} = cur;
    assign glyph[0]  = tens(snap[23:16]);
    assign glyph[1]  = ones(snap[23:16]);
    assign glyph[2]  = 4'd10;
    assign glyph[3]  = tens(snap[15:8]);
    assign glyph[4]  = ones(snap[15:8]);
    assign glyph[5]  = 4'd10;
    assign glyph[6]  = tens(snap[7:0]);
    assign glyph[7]  = ones(snap[7:0]);
    assign font_code = glyph[chr];
    assign font_row  = row;

    assign drawing  = state == DRAW;
    assign pixel_fg = font_bits[~col];
`ifdef TIME_RENDER_TRANSPARENT_EN
    assign im_req   = drawing && pixel_fg;
    assign advance  = 1'b1;
`else
    assign im_req   = drawing;
    assign advance  = im_gnt;
`endif
    assign im_wen_n = !(im_req && im_gnt);
    assign im_a     = drawing ? fb_addr + ORIGIN + {9'd0, row, 8'd0} + {14'd0, chr, col} : '0;
    assign im_d     = drawing ? (pixel_fg ? FG_RGB : BG_RGB) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cur   <= '0;
            snap  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SNAP;
                    busy  <= 1'b1;
                end
                SNAP: begin
                    snap  <= curr_time;
                    cur   <= '0;
                    state <= DRAW;
                end
                DRAW: if (advance) begin
                    cur <= cur + 9'd1;
                    if (&cur) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
